// File: rtl/codec_config_sequencer.sv
// Audio codec power-up sequencer: walks a fixed register table over an I2C
// write-command handshake, with NACK retries, a post-reset settle wait and volume tracking.
module codec_config_sequencer #(
    parameter logic [7:0] DEV_ADDR      = 8'h34,
    parameter int         MAX_RETRY     = 3,
    parameter int         SETTLE_CYCLES = 1000,
    parameter int         AUTO_START    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  hp_vol,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [23:0] cmd_data,
    input  logic        xfer_done,
    input  logic        ack_err,
    output logic        busy,
    output logic        configured,
    output logic        error,
    output logic [3:0]  index
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);
    localparam logic [SW-1:0] SETTLE_LAST = (SETTLE_CYCLES < 1) ? '0 : SW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_SETTLE = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t          state_r;
    logic [RW-1:0]   retry_r;
    logic [SW-1:0]   settle_r;
    logic [6:0]      vol_q;
    logic            vol_only_r;
    logic            auto_pend_r;

    // Codec register table; entry 6 carries the headphone volume.
    function automatic logic [15:0] reg_word(input logic [3:0] idx, input logic [6:0] vol);
        case (idx)
            4'd0:    reg_word = 16'h1E00;
            4'd1:    reg_word = 16'h0C10;
            4'd2:    reg_word = 16'h0812;
            4'd3:    reg_word = 16'h0A00;
            4'd4:    reg_word = 16'h0E01;
            4'd5:    reg_word = 16'h1000;
            4'd6:    reg_word = 16'h0500 | {9'd0, vol};
            4'd7:    reg_word = 16'h0C00;
            4'd8:    reg_word = 16'h1201;
            default: reg_word = 16'h0000;
        endcase
    endfunction

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            cmd_valid   <= 1'b0;
            cmd_data    <= 24'h000000;
            busy        <= 1'b0;
            configured  <= 1'b0;
            error       <= 1'b0;
            index       <= 4'd0;
            retry_r     <= '0;
            settle_r    <= '0;
            vol_q       <= 7'd0;
            vol_only_r  <= 1'b0;
            auto_pend_r <= (AUTO_START != 0);
        end else begin
            case (state_r)
                S_IDLE, S_DONE, S_ERROR: begin
                    // Start wins over a pending volume update.
                    if (start || (state_r == S_IDLE && auto_pend_r)) begin
                        state_r     <= S_ISSUE;
                        index       <= 4'd0;
                        cmd_valid   <= 1'b1;
                        cmd_data    <= {DEV_ADDR, reg_word(4'd0, hp_vol)};
                        busy        <= 1'b1;
                        configured  <= 1'b0;
                        error       <= 1'b0;
                        retry_r     <= '0;
                        vol_only_r  <= 1'b0;
                        auto_pend_r <= 1'b0;
                    end else if (state_r == S_DONE && hp_vol != vol_q) begin
                        state_r    <= S_ISSUE;
                        index      <= 4'd6;
                        cmd_valid  <= 1'b1;
                        cmd_data   <= {DEV_ADDR, reg_word(4'd6, hp_vol)};
                        busy       <= 1'b1;
                        configured <= 1'b0;
                        retry_r    <= '0;
                        vol_only_r <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        state_r   <= S_WAIT;
                        cmd_valid <= 1'b0;
                        if (index == 4'd6) begin
                            vol_q <= hp_vol;
                        end
                    end else if (index == 4'd6) begin
                        cmd_data <= {DEV_ADDR, reg_word(4'd6, hp_vol)};
                    end
                end
                S_WAIT: begin
                    if (xfer_done && !ack_err) begin
                        retry_r <= '0;
                        if (index == 4'd0) begin
                            state_r  <= S_SETTLE;
                            settle_r <= '0;
                        end else if (index == 4'd8 || vol_only_r) begin
                            state_r    <= S_DONE;
                            busy       <= 1'b0;
                            configured <= 1'b1;
                            vol_only_r <= 1'b0;
                        end else begin
                            state_r   <= S_ISSUE;
                            index     <= index + 4'd1;
                            cmd_valid <= 1'b1;
                            cmd_data  <= {DEV_ADDR, reg_word(index + 4'd1, hp_vol)};
                        end
                    end else if (xfer_done && ack_err) begin
                        if (retry_r < RETRY_MAX) begin
                            state_r   <= S_ISSUE;
                            retry_r   <= retry_r + 1'b1;
                            cmd_valid <= 1'b1;
                            cmd_data  <= {DEV_ADDR, reg_word(index, hp_vol)};
                        end else begin
                            state_r    <= S_ERROR;
                            busy       <= 1'b0;
                            error      <= 1'b1;
                            vol_only_r <= 1'b0;
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_r == SETTLE_LAST) begin
                        state_r   <= S_ISSUE;
                        settle_r  <= '0;
                        index     <= 4'd1;
                        cmd_valid <= 1'b1;
                        cmd_data  <= {DEV_ADDR, reg_word(4'd1, hp_vol)};
                    end else begin
                        settle_r <= settle_r + 1'b1;
                    end
                end
                default: begin
                    state_r    <= S_IDLE;
                    cmd_valid  <= 1'b0;
                    busy       <= 1'b0;
                    configured <= 1'b0;
                    error      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Directed bench: an I2C master model answers commands while scenario tasks
// check command order, retries, error stop, volume tracking, stall and reset.
module tb_codec_config_sequencer;

    localparam int SETTLE = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  hp_vol = 7'h79;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [23:0] cmd_data;
    logic        xfer_done = 1'b0;
    logic        ack_err = 1'b0;
    logic        busy, configured, error;
    logic [3:0]  index;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [23:0] log_q[$];
    int          log_t[$];
    logic [15:0] nack_word = 16'hFFFF;
    int          nack_limit = 0;
    bit          hold_ready = 1'b0;
    int          clear_req = 0;
    int          m_state = 0;

    logic [23:0] exp_cfg [0:8] = '{24'h341E00, 24'h340C10, 24'h340812, 24'h340A00,
                                   24'h340E01, 24'h341000, 24'h340579, 24'h340C00, 24'h341201};

    codec_config_sequencer #(
        .DEV_ADDR(8'h34), .MAX_RETRY(3), .SETTLE_CYCLES(SETTLE), .AUTO_START(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .hp_vol(hp_vol),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .xfer_done(xfer_done), .ack_err(ack_err),
        .busy(busy), .configured(configured), .error(error), .index(index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // I2C master model: ready 2 cycles after valid, transaction end 3 cycles after accept.
    initial begin
        int cnt;
        int nacks;
        int clear_seen;
        logic [23:0] last;
        cnt = 0; nacks = 0; clear_seen = 0;
        forever begin
            @(negedge clk);
            cmd_ready = 1'b0; xfer_done = 1'b0; ack_err = 1'b0;
            if (clear_req != clear_seen) begin
                clear_seen = clear_req; m_state = 0; cnt = 0; nacks = 0;
            end else if (m_state == 0) begin
                if (cmd_valid && !hold_ready) begin
                    cnt++;
                    if (cnt >= 2) begin
                        cmd_ready = 1'b1;
                        log_q.push_back(cmd_data);
                        log_t.push_back(cyc);
                        cnt = 0;
                        m_state = 1;
                    end
                end else begin
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt == 3) begin
                    xfer_done = 1'b1;
                    last = log_q[log_q.size()-1];
                    if (last[15:0] == nack_word && nacks < nack_limit) begin
                        ack_err = 1'b1;
                        nacks++;
                    end
                    cnt = 0;
                    m_state = 0;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({cmd_valid, cmd_data, busy, configured, error, index} !== 32'd0) begin
            errors++;
            $display("FAIL %s: valid=%b data=%h busy=%b cfg=%b err=%b idx=%0d, required all zero",
                     tag, cmd_valid, cmd_data, busy, configured, error, index);
        end
    endtask

    task automatic wait_configured(input string tag, input int bound);
        int n = 0;
        while (!configured && n < bound) begin tick(); n++; end
        checks++;
        if (configured !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: configured=%b after %0d cycles, required 1", tag, configured, n);
        end
    endtask

    function automatic int count_word(input int base, input logic [23:0] w);
        int c = 0;
        for (int i = base; i < log_q.size(); i++) if (log_q[i] == w) c++;
        return c;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        check_all_zero("reset_state");
        clear_req++;
        reset = 1'b0;
    endtask

    task automatic test_full_config();
        int base = log_q.size();
        wait_configured("full_cfg", 3000);
        checks++;
        if (log_q.size() - base != 9) begin
            errors++;
            $display("FAIL full_cfg_count: got %0d commands, required 9", log_q.size() - base);
        end
        for (int i = 0; i < 9; i++) begin
            if (base + i < log_q.size()) begin
                checks++;
                if (log_q[base+i] !== exp_cfg[i]) begin
                    errors++;
                    $display("FAIL full_cfg_cmd%0d: got %h, required %h", i, log_q[base+i], exp_cfg[i]);
                end
            end
        end
        if (log_t.size() >= base + 2) begin
            checks++;
            if (log_t[base+1] - log_t[base] < SETTLE) begin
                errors++;
                $display("FAIL settle_gap: got %0d cycles, required >= %0d", log_t[base+1] - log_t[base], SETTLE);
            end
        end
        checks++;
        if ({busy, error} !== 2'b00) begin
            errors++;
            $display("FAIL full_cfg_flags: busy=%b error=%b, required 0 0", busy, error);
        end
    endtask

    task automatic test_volume();
        int base = log_q.size();
        int n = 0;
        hp_vol = 7'h50;
        while (!busy && n < 20) begin tick(); n++; end
        wait_configured("volume", 300);
        repeat (20) tick();
        checks++;
        if (log_q.size() - base != 1) begin
            errors++;
            $display("FAIL volume_count: got %0d commands, required 1", log_q.size() - base);
        end else begin
            checks++;
            if (log_q[base] !== 24'h340550) begin
                errors++;
                $display("FAIL volume_cmd: got %h, required 340550", log_q[base]);
            end
        end
        checks++;
        if (configured !== 1'b1 || index !== 4'd6) begin
            errors++;
            $display("FAIL volume_done: configured=%b index=%0d, required 1 and 6", configured, index);
        end
    endtask

    task automatic test_nack_retry();
        int base = log_q.size();
        nack_word = 16'h0A00; nack_limit = 2; clear_req++;
        pulse_start();
        wait_configured("nack_retry", 3000);
        checks++;
        if (count_word(base, 24'h340A00) != 3) begin
            errors++;
            $display("FAIL retry_count: 340A00 sent %0d times, required 3", count_word(base, 24'h340A00));
        end
        checks++;
        if (log_q.size() - base != 11) begin
            errors++;
            $display("FAIL retry_total: got %0d commands, required 11", log_q.size() - base);
        end
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL retry_error: error=%b, required 0", error);
        end
    endtask

    task automatic test_nack_error();
        int base = log_q.size();
        int n = 0;
        int vcount = 0;
        int after;
        nack_word = 16'h0812; nack_limit = 100; clear_req++;
        pulse_start();
        while (!error && n < 3000) begin tick(); n++; end
        checks++;
        if (count_word(base, 24'h340812) != 4) begin
            errors++;
            $display("FAIL err_count: 340812 sent %0d times, required 4", count_word(base, 24'h340812));
        end
        checks++;
        if ({error, busy, configured} !== 3'b100) begin
            errors++;
            $display("FAIL err_flags: error=%b busy=%b cfg=%b, required 1 0 0", error, busy, configured);
        end
        after = log_q.size();
        repeat (30) begin tick(); if (cmd_valid) vcount++; end
        checks++;
        if (vcount != 0 || log_q.size() != after) begin
            errors++;
            $display("FAIL err_quiet: cmd_valid seen %0d cycles, %0d new commands, required 0 0",
                     vcount, log_q.size() - after);
        end
    endtask

    task automatic test_hold_ready();
        int n = 0;
        nack_word = 16'hFFFF; nack_limit = 0; clear_req++;
        hold_ready = 1'b1;
        pulse_start();
        while (!cmd_valid && n < 10) begin tick(); n++; end
        for (int i = 0; i < 50; i++) begin
            checks++;
            if (cmd_valid !== 1'b1 || cmd_data !== 24'h341E00) begin
                errors++;
                $display("FAIL hold_stable: cycle %0d valid=%b data=%h, required 1 341e00", i, cmd_valid, cmd_data);
            end
            tick();
        end
        hold_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int n = 0;
        int base;
        logic [23:0] last;
        bit found = 1'b0;
        while (!found && n < 3000) begin
            if (m_state == 1 && log_q.size() > 0) begin
                last = log_q[log_q.size()-1];
                if (last == 24'h341000) found = 1'b1;
            end
            if (!found) begin tick(); n++; end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midwait_reach: entry 5 wait not reached, required reached");
        end
        reset = 1'b1; clear_req++;
        tick();
        check_all_zero("midwait_reset");
        reset = 1'b0;
        base = log_q.size();
        n = 0;
        while (log_q.size() == base && n < 100) begin tick(); n++; end
        checks++;
        if (log_q.size() == base || log_q[base] !== 24'h341E00) begin
            errors++;
            $display("FAIL midwait_restart: got %h, required 341e00",
                     (log_q.size() > base) ? log_q[base] : 24'h0);
        end
        wait_configured("midwait_done", 3000);
    endtask

    initial begin
        test_reset();
        test_full_config();
        test_volume();
        test_nack_retry();
        test_nack_error();
        test_hold_ready();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
